// File: rtl/fifo_stream.sv
// Single-clock first-word-fall-through FIFO with valid/ready on both sides,
// occupancy count, almost-full/empty flags, synchronous flush and sticky overflow.
module fifo_stream #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Flush,
    input  logic             i_Wr_Valid,
    input  logic [WIDTH-1:0] i_Wr_Data,
    output logic             o_Wr_Ready,
    output logic             o_Rd_Valid,
    output logic [WIDTH-1:0] o_Rd_Data,
    input  logic             i_Rd_Ready,
    output logic [CW-1:0]    o_Count,
    input  logic [CW-1:0]    i_AF_Level,
    input  logic [CW-1:0]    i_AE_Level,
    output logic             o_AF_Flag,
    output logic             o_AE_Flag,
    output logic             o_Full,
    output logic             o_Empty,
    output logic             o_Overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             overflow;

    logic wr_ready;
    logic wr_hs;
    logic rd_hs;
    logic load;
    logic arr_empty;
    logic arr_rd;
    logic arr_wr;
    logic bypass;
    logic [CW:0] af_sum;

    // Pointers wrap by compare so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign wr_ready  = !i_Rst && !i_Flush && (count != DEPTH_C);
    assign wr_hs     = i_Wr_Valid && wr_ready;
    assign rd_hs     = rd_valid && i_Rd_Ready;
    assign load      = !rd_valid || rd_hs;
    // Words held in the array exclude the one sitting in the output register.
    assign arr_empty = ((count - CW'(rd_valid)) == '0);
    assign arr_rd    = load && !arr_empty;
    assign bypass    = load && arr_empty && wr_hs;
    assign arr_wr    = wr_hs && !bypass;

    always_ff @(posedge i_Clk) begin
        if (arr_wr) begin
            mem[wr_ptr] <= i_Wr_Data;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            overflow <= 1'b0;
        end else if (i_Flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (arr_wr) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (arr_rd) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (load) begin
                if (arr_rd) begin
                    rd_data  <= mem[rd_ptr];
                    rd_valid <= 1'b1;
                end else if (wr_hs) begin
                    rd_data  <= i_Wr_Data;
                    rd_valid <= 1'b1;
                end else begin
                    rd_valid <= 1'b0;
                end
            end
            case ({wr_hs, rd_hs})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (i_Wr_Valid && !wr_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    // Sum is one bit wider than the count so a large level cannot wrap.
    assign af_sum     = {1'b0, count} + {1'b0, i_AF_Level};
    assign o_AF_Flag  = (af_sum >= (CW + 1)'(DEPTH));
    assign o_AE_Flag  = (count <= i_AE_Level);
    assign o_Full     = (count == DEPTH_C);
    assign o_Empty    = (count == '0);
    assign o_Count    = count;
    assign o_Wr_Ready = wr_ready;
    assign o_Rd_Valid = rd_valid;
    assign o_Rd_Data  = rd_data;
    assign o_Overflow = overflow;

endmodule
